// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO pair.
// Shift-add multiply and restoring divide run on magnitudes; the sign is fixed up in one extra cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);
    localparam int ITER = WIDTH;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state, w_next;
    logic               w_busy, w_fix, w_start, w_mt;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_neg, r_sa;
    logic [WIDTH-1:0]   r_b, r_rem, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy  = (r_state != S_IDLE);
        w_fix   = (r_state == S_FIX);
        w_start = (r_state == S_IDLE) && Start;
        w_mt    = (r_state == S_IDLE) && !Start;
    end

    // Operand magnitudes; unsigned ops (Op[0]=1) pass through raw
    logic             w_sa, w_sb;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    always_comb begin
        w_sa    = ~Op[0] & A[WIDTH-1];
        w_sb    = ~Op[0] & B[WIDTH-1];
        w_abs_a = w_sa ? -A : A;
        w_abs_b = w_sb ? -B : B;
    end

    // One iteration of each algorithm
    logic [WIDTH:0]     w_addend, w_madd, w_rsh, w_diff;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH-1:0]   w_q_nxt, w_rem_nxt;
    always_comb begin
        w_addend  = r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}};
        w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
        w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};
        w_rsh     = {r_rem, r_acc[WIDTH-1]};
        w_diff    = w_rsh - {1'b0, r_b};
        w_q_nxt   = {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
        // Partial remainder stays below the divisor, so WIDTH bits suffice after the compare
        w_rem_nxt = w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end

    // Sign correction; divide-by-zero forces an all-ones quotient, remainder already equals A
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;
    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quo  = (r_b == '0) ? {WIDTH{1'b1}}
               : (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        w_rem  = r_sa ? -r_rem : r_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_neg <= 1'b0;
            r_sa  <= 1'b0;
            r_b   <= '0;
            r_rem <= '0;
            r_acc <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_div <= Op[1];
            r_neg <= w_sa ^ w_sb;
            r_sa  <= w_sa;
            r_b   <= w_abs_b;
            r_rem <= '0;
            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
                r_acc[WIDTH-1:0] <= w_q_nxt;
                r_rem            <= w_rem_nxt;
            end else begin
                r_acc <= w_mul_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_fix) begin
                if (r_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if (w_mt) begin
                if (HiWrite) r_hi <= A;
                if (LoWrite) r_lo <= A;
            end
        end
    end

    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Busy = w_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [31:0] A = '0, B = '0;
    logic        HiWrite = 1'b0, LoWrite = 1'b0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done;

    int n_chk = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics straight from integer arithmetic
    task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint     sp;
        logic [63:0] up;
        int         sa, sb;
        sa = a; sb = b;
        case (op)
            2'd0: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            2'd2: begin
                if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // Launch one op; optionally poke Start+HiWrite at busy cycle `inject`, or MT writes alongside Start
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input logic mtw);
        logic [31:0] eh, el;
        int busy;
        ref_op(op, a, b, eh, el);
        @(negedge clk);
        Start = 1'b1; Op = op; A = a; B = b; HiWrite = mtw; LoWrite = mtw;
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            if (!Busy) break;
            busy++;
            if (busy == 16) begin
                chk("hold_hi", Hi, m_hi);
                chk("hold_lo", Lo, m_lo);
            end
            if (busy == inject) begin
                Start = 1'b1; HiWrite = 1'b1; A = $urandom; B = $urandom;
            end else begin
                Start = 1'b0; HiWrite = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0; HiWrite = 1'b0;
        chk("busy_cycles", busy, 33);
        chk("done_pulse", Done, 1);
        chk("hi", Hi, eh);
        chk("lo", Lo, el);
        m_hi = eh; m_lo = el;
        @(negedge clk);
        chk("done_clear", Done, 0);
        chk("busy_idle", Busy, 0);
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [31:0] a);
        @(negedge clk);
        HiWrite = hw; LoWrite = lw; A = a;
        @(negedge clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        if (hw) m_hi = a;
        if (lw) m_lo = a;
        chk("mt_hi", Hi, m_hi);
        chk("mt_lo", Lo, m_lo);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int sel;
        #12;
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, 1'b0);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        run_op(2'd3, 32'd100, 32'd0, 0, 1'b0);
        mt_write(1'b1, 1'b1, 32'h12345678);
        run_op(2'd3, 32'd100, 32'd7, 5, 1'b0);
        run_op(2'd2, 32'hFFFFFF00, 32'd0, 0, 1'b1);

        // Asynchronous reset mid-MULT
        @(negedge clk);
        Start = 1'b1; Op = 2'd0; A = 32'h00001234; B = 32'hFFFF0001;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_hi", Hi, 0);
        chk("arst_lo", Lo, 0);
        chk("arst_done", Done, 0);
        m_hi = 0; m_lo = 0;
        @(negedge clk); rst_n = 1'b1;
        run_op(2'd1, 32'd6, 32'd7, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 20));
            else if (sel == 3) a = 32'($urandom_range(0, 50));
            run_op(op, a, b, (sel == 4) ? int'($urandom_range(1, 32)) : 0, (sel == 5));
            if ($urandom_range(0, 1) == 1)
                mt_write(1'($urandom), 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit that holds the HI/LO register pair.
- Sits directly downstream of the register file. It takes the two read-data outputs (DR1 as operand A, DR2 as operand B) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Hi/Lo are read back into the register file WriteData path by MFHI/MFLO.
- Multi-cycle, with a Busy/Done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, iterations per operation. Fixed equal to WIDTH; not independently changeable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  launch an operation; sampled only when Busy=0.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  operand A (rs, from DR1).
- B  input  WIDTH  operand B (rt, from DR2).
- HiWrite  input  1  MTHI: Hi <= A.
- LoWrite  input  1  MTLO: Lo <= A.
- Hi  output  WIDTH  HI register (remainder / upper product).
- Lo  output  WIDTH  LO register (quotient / lower product).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: Hi/Lo just updated by an operation.

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-operation):
  - Hi=0, Lo=0, Busy=0, Done=0.
  - State IDLE; iteration counter and internal accumulators cleared.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - On an edge with Start=1, latch Op.
  - Latch |A| and |B| (two's-complement magnitude for signed ops; raw values for unsigned ops).
  - Latch the result-sign flags; clear counter; go to RUN.
  - Busy=1 from the following cycle.
- RUN: one iteration per edge for exactly WIDTH edges, then go to FIX.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring; WIDTH-bit remainder plus one guard bit.
- FIX (one edge):
  - Apply sign correction and write Hi/Lo.
  - Return to IDLE; Busy=0 and Done=1 for exactly the next cycle.
- Latency: Start edge at cycle 0 -> Hi/Lo updated and Done high after edge WIDTH+1 (33). Busy high for WIDTH+1 cycles.
- MULT/MULTU: {Hi,Lo} = full 2*WIDTH-bit product. MULT result is negated if sign(A) xor sign(B).
- DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed quotient: truncated toward zero, negated if sign(A) xor sign(B).
  - Signed remainder: takes the sign of A.
- Divide by zero (B=0, DIV or DIVU): Lo=all ones, Hi=A (raw). Same latency; no exception.
- DIV of most-negative by -1: Lo=0x80000000, Hi=0; no trap.
- HiWrite/LoWrite:
  - Applied on the edge only while Busy=0 and Start=0; both may be asserted together.
  - Ignored while Busy=1.
  - When Start=1 in the same cycle, Start wins and the writes are dropped.
- Start while Busy=1: ignored; no queuing.
- Hi/Lo hold their previous values throughout RUN; they update only in FIX or via MTHI/MTLO.
- Operands A/B and Op need only be valid in the Start cycle; later changes have no effect.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles Hi=0xFFFFFFFE, Lo=0x00000001, Done pulse 1 cycle, Busy high exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Also DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064. Then in IDLE, HiWrite=1 and LoWrite=1 with A=0x12345678 -> both Hi and Lo=0x12345678 next edge.
- DIVU A=100, B=7 started; Start with new operands plus HiWrite at cycle 5 -> both ignored. Result Lo=14, Hi=2 at cycle 33.
- MULT started, rst_n pulled low at cycle 10 between edges -> Busy, Hi, Lo, Done immediately 0. After release, a fresh MULTU 6*7 gives Lo=42, Hi=0 at 33 cycles.
